// File: rtl/dccm_pkg.sv
// rtl/dccm_pkg.sv - shared types, constants and parity helper for the DCCM bank controller
package dccm_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam int RSP_FIFO_DEPTH = 2;

  // Even parity: the stored bit makes the total count of ones in the lane even.
  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dccm_lane_ram.sv
// rtl/dccm_lane_ram.sv - one byte lane of the bank (data plus optional parity), synchronous read
module dccm_lane_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dccm_bank_ctrl.sv
// rtl/dccm_bank_ctrl.sv - single-port DCCM bank with post-reset clear and 2-entry read response FIFO
// Optional per-byte parity and error injection enabled by defining DCCM_PARITY_EN.
module dccm_bank_ctrl
  import dccm_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [DW/8-1:0]          req_be,
  input  logic [DW-1:0]            req_wdata,
`ifdef DCCM_PARITY_EN
  input  logic                     inj_par_err,
`endif
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DW-1:0]            rsp_rdata,
  output logic                     rsp_err,
  output logic                     init_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = DW / 8;
`ifdef DCCM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam logic [1:0] FIFO_DEPTH = RSP_FIFO_DEPTH[1:0];

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt;
  logic            inflight;
  logic [DW-1:0]   fifo_data [RSP_FIFO_DEPTH];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;
  logic [1:0]      occ;
  logic            pop, accept, rd_en, init_mode;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   rd_data;
  logic [NB-1:0]   lane_we;
  logic [LW-1:0]   lane_wd [NB];
  logic [LW-1:0]   lane_rd [NB];

  assign init_mode = (state_q == INIT);
  assign init_done = (state_q == RUN);
  assign rsp_valid = (count != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign occ       = count + {1'b0, inflight};
  // The slot freed by a same-cycle pop may be reused immediately.
  assign req_ready = (state_q == RUN) && ((occ - {1'b0, pop}) < FIFO_DEPTH);
  assign accept    = req_valid & req_ready;
  assign rd_en     = accept & ~req_we;
  assign ram_addr  = init_mode ? clr_cnt : req_addr;
  assign rsp_rdata = fifo_data[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && clr_cnt == '1) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         clr_cnt <= '0;
    else if (init_mode) clr_cnt <= clr_cnt + 1'b1;
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [7:0] wbyte;
    assign wbyte      = init_mode ? 8'h00 : req_wdata[8*i +: 8];
    assign lane_we[i] = init_mode | (accept & req_we & req_be[i]);
`ifdef DCCM_PARITY_EN
    assign lane_wd[i] = {parity8(wbyte) ^ (inj_par_err & ~init_mode), wbyte};
`else
    assign lane_wd[i] = wbyte;
`endif
    assign rd_data[8*i +: 8] = lane_rd[i][7:0];

    dccm_lane_ram #(.DEPTH(DEPTH), .AW(AW), .W(LW)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .re    (rd_en),
      .addr  (ram_addr),
      .wdata (lane_wd[i]),
      .rdata (lane_rd[i])
    );
  end

`ifdef DCCM_PARITY_EN
  logic [NB-1:0] lane_err;
  logic          fifo_err [RSP_FIFO_DEPTH];

  for (genvar i = 0; i < NB; i++) begin : g_par
    assign lane_err[i] = lane_rd[i][8] ^ parity8(lane_rd[i][7:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RSP_FIFO_DEPTH; k++) fifo_err[k] <= 1'b0;
    end else if (inflight) begin
      fifo_err[wr_ptr] <= |lane_err;
    end
  end

  assign rsp_err = fifo_err[rd_ptr];
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      for (int k = 0; k < RSP_FIFO_DEPTH; k++) fifo_data[k] <= '0;
    end else begin
      inflight <= rd_en;
      if (inflight) begin
        fifo_data[wr_ptr] <= rd_data;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dccm_bank_ctrl.sv
// tb/tb_dccm_bank_ctrl.sv - directed vector bench for dccm_bank_ctrl (DW=32, DEPTH=16)
module tb_dccm_bank_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NB    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [NB-1:0] req_be = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_done;
`ifdef DCCM_PARITY_EN
  logic          inj_par_err = 1'b0;
`endif

  dccm_bank_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
`ifdef DCCM_PARITY_EN
    .inj_par_err (inj_par_err),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] got_d[$];
  int          got_c[$];
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      got_d.push_back(rsp_rdata);
      got_c.push_back(cyc);
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [NB-1:0] be;
    logic [31:0]   wdata;
    logic [31:0]   exp;
  } vec_t;

  vec_t vt[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [NB-1:0] be,
                        input logic [31:0] wdata);
    int n;
    req_we = we; req_addr = addr; req_be = be; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] addr,
                            input logic [31:0] exp, input logic exp_err);
    int n;
    rsp_ready = 1'b1;
    do_req(1'b0, addr, '0, '0);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    check(name, {31'd0, rsp_err, rsp_rdata}, {31'd0, exp_err, exp});
    step();
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done && n < 100) begin step(); n++; end
    check(name, 64'(n), 64'd16);
    check({name, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  logic [31:0] exp8 [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) vt.push_back('{1'b0, AW'(a), 4'h0, 32'h0, 32'h0});
    vt.push_back('{1'b1, 4'd5,  4'hf, 32'hDEADBEEF, 32'h0});
    vt.push_back('{1'b1, 4'd5,  4'h4, 32'h00AA0000, 32'h0});
    vt.push_back('{1'b0, 4'd5,  4'h0, 32'h0,        32'hDEAABEEF});
    vt.push_back('{1'b1, 4'd5,  4'h0, 32'hFFFFFFFF, 32'h0});
    vt.push_back('{1'b0, 4'd5,  4'h0, 32'h0,        32'hDEAABEEF});
    vt.push_back('{1'b1, 4'd0,  4'h1, 32'hFFFFFFA5, 32'h0});
    vt.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        32'h000000A5});
    vt.push_back('{1'b1, 4'd9,  4'ha, 32'hCAFEF00D, 32'h0});
    vt.push_back('{1'b0, 4'd9,  4'h0, 32'h0,        32'hCA00F000});
    vt.push_back('{1'b1, 4'd15, 4'hf, 32'h12345678, 32'h0});
    vt.push_back('{1'b0, 4'd15, 4'h0, 32'h0,        32'h12345678});
    vt.push_back('{1'b1, 4'd1,  4'hf, 32'h11111111, 32'h0});
    vt.push_back('{1'b1, 4'd2,  4'hf, 32'h22222222, 32'h0});
    vt.push_back('{1'b1, 4'd3,  4'hf, 32'h33333333, 32'h0});
    vt.push_back('{1'b0, 4'd1,  4'h0, 32'h0,        32'h11111111});
    vt.push_back('{1'b0, 4'd2,  4'h0, 32'h0,        32'h22222222});
    vt.push_back('{1'b0, 4'd3,  4'h0, 32'h0,        32'h33333333});
    exp8 = '{32'h000000A5, 32'h11111111, 32'h22222222, 32'h33333333,
             32'h0, 32'hDEAABEEF, 32'h0, 32'h0};

    // Reset state
    step(); step();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    rst_n = 1'b1;
    wait_init("init_cycles");

    // Table-driven vectors
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].we) do_req(1'b1, vt[i].addr, vt[i].be, vt[i].wdata);
      else          read_check($sformatf("vec%0d_addr%0d", i, vt[i].addr), vt[i].addr, vt[i].exp, 1'b0);
    end

    // Back-pressure: two reads fill occupancy, third waits
    got_d.delete(); got_c.delete();
    rsp_ready = 1'b0;
    req_we = 1'b0; req_be = '0; req_addr = 4'd1; req_valid = 1'b1;
    check("bp_ready_first", 64'(req_ready), 64'd1);
    step();
    req_addr = 4'd2;
    check("bp_ready_second", 64'(req_ready), 64'd1);
    step();
    check("bp_ready_full", 64'(req_ready), 64'd0);
    req_addr = 4'd3;
    step(); step();
    check("bp_ready_held", 64'(req_ready), 64'd0);
    check("bp_rsp_held", {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b1, 32'h11111111});
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    for (int n = 0; n < 20 && got_d.size() < 3; n++) step();
    check("bp_count", 64'(got_d.size()), 64'd3);
    for (int i = 0; i < 3 && i < got_d.size(); i++)
      check($sformatf("bp_rsp%0d", i), 64'(got_d[i]), 64'(exp8[i+1]));

    // Back-to-back reads with rsp_ready high
    step();
    got_d.delete(); got_c.delete();
    begin
      int acc;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
        req_we = 1'b0; req_addr = AW'(i); req_valid = 1'b1;
        check($sformatf("b2b_ready%0d", i), 64'(req_ready), 64'd1);
        step();
        if (i == 0) acc = cyc;
      end
      req_valid = 1'b0;
      for (int n = 0; n < 20 && got_d.size() < 8; n++) step();
      check("b2b_count", 64'(got_d.size()), 64'd8);
      for (int i = 0; i < 8 && i < got_d.size(); i++) begin
        check($sformatf("b2b_data%0d", i),  64'(got_d[i]), 64'(exp8[i]));
        check($sformatf("b2b_cycle%0d", i), 64'(got_c[i]), 64'(acc + 1 + i));
      end
    end

    // Reset with two responses pending
    step();
    rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 4'd5; req_valid = 1'b1;
    step();
    req_addr = 4'd6;
    step();
    req_valid = 1'b0;
    step();
    check("mid_pending", 64'(rsp_valid), 64'd1);
    got_d.delete(); got_c.delete();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    wait_init("reinit_cycles");
    step(); step();
    check("mid_no_stale", 64'(got_d.size()), 64'd0);
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    read_check("mid_cleared_addr5", 4'd5, 32'h0, 1'b0);

`ifdef DCCM_PARITY_EN
    inj_par_err = 1'b1;
    do_req(1'b1, 4'd3, 4'hf, 32'h5A5A1234);
    inj_par_err = 1'b0;
    read_check("par_injected", 4'd3, 32'h5A5A1234, 1'b1);
    do_req(1'b1, 4'd3, 4'hf, 32'h5A5A1234);
    read_check("par_clean", 4'd3, 32'h5A5A1234, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dccm_bank_ctrl.md
DCCM_BANK_CTRL -- requirements
Module: dccm_bank_ctrl

Interface
REQ-001 Parameter DW, default 32, SHALL set the data word width in bits; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 1024, SHALL set the number of words; it must be a power of two, minimum 16.
REQ-003 Localparams SHALL be AW = log2(DEPTH) and NB = DW/8.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 req_valid / req_ready  in / out  1 / 1  request handshake; a request transfers when both are high at a rising edge.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  AW  word address.
REQ-009 req_be  in  NB  byte-lane write enables; ignored for reads.
REQ-010 req_wdata  in  DW  write data.
REQ-011 rsp_valid / rsp_ready  out / in  1 / 1  read-response handshake.
REQ-012 rsp_rdata  out  DW  read data.
REQ-013 rsp_err  out  1  parity error on the response; it is tied to 0 when parity is compiled out.
REQ-014 init_done  out  1  high once the post-reset memory clear has completed.

Function
REQ-015 FSM states SHALL be INIT and RUN; reset SHALL enter INIT, and the FSM SHALL go INIT->RUN after the cycle in which the clear counter writes address DEPTH-1; RUN is terminal.
REQ-016 In INIT, the block SHALL write zero to all NB lanes at the address given by the clear counter, incrementing by 1 per cycle, so the clear takes exactly DEPTH cycles; req_ready SHALL stay 0.
REQ-017 A write SHALL update only the lanes whose req_be bit is 1 and SHALL produce no response; req_be = 0 is a legal no-op.
REQ-018 A read SHALL access the RAM in the acceptance cycle, and its data SHALL enter a 2-entry response FIFO on the next edge; minimum latency from acceptance to rsp_valid is 1 cycle.
REQ-019 A read accepted in the cycle after a write to the same address SHALL return the new data.
REQ-020 Responses SHALL be returned strictly in request order.
REQ-021 Occupancy is defined as FIFO count plus reads in flight (0..1); req_ready SHALL equal (state==RUN) && (occupancy - pop < 2), where pop = rsp_valid & rsp_ready.
REQ-022 With rsp_ready held high, the block SHALL accept one read per cycle.
REQ-023 rsp_valid SHALL remain asserted, and rsp_rdata/rsp_err SHALL remain stable, until a pop occurs.
REQ-024 Writes SHALL be accepted while responses are back-pressured, provided occupancy is below 2.
REQ-025 The RAM SHALL be single-ported, with at most one access per cycle; no read/write collision case exists.

Reset
REQ-026 While rst_n=0: rsp_valid=0, req_ready=0, init_done=0, rsp_rdata=0, rsp_err=0, FIFO empty, in-flight cleared, clear counter=0, state=INIT.
REQ-027 Reset asserted mid-clear or mid-traffic SHALL discard all pending responses and restart the clear from address 0.
REQ-028 Memory contents are not reset directly; they are zeroed only by the INIT sequence.

Configuration
REQ-029 With DCCM_PARITY_EN defined, the block SHALL store one even-parity bit per byte lane on every write (clears included), recompute parity on each read, and set rsp_err=1 if any lane mismatches.
REQ-030 With DCCM_PARITY_EN defined, an added input port inj_par_err (1 bit) SHALL invert the stored parity bits for all lanes written by that request.
REQ-031 Without DCCM_PARITY_EN, the block SHALL have no parity storage and no inj_par_err port, and rsp_err SHALL be constant 0.

Structure
REQ-032 Package dccm_pkg SHALL hold the INIT/RUN state enum, the FIFO depth constant (2), and the per-byte parity function.
REQ-033 Sub-module dccm_lane_ram (one byte lane: 8 data bits plus an optional parity bit, synchronous read, per-lane write enable) SHALL be instantiated NB times.

Verification
REQ-034 Release reset, DW=32, DEPTH=16 -> init_done and req_ready rise after exactly 16 cycles; a read of every address returns 0x00000000.
REQ-035 Write 0xDEADBEEF with be=4'b1111 to addr 5, then write 0x00AA0000 with be=4'b0100 to addr 5, then read addr 5 -> 0xDEAABEEF.
REQ-036 Hold rsp_ready=0 and issue reads to addr 1, 2, 3 -> req_ready drops after 2 reads; releasing rsp_ready returns data for 1, 2, 3 in order, with no loss.
REQ-037 rsp_ready=1 with back-to-back reads of addr 0..7 -> 8 responses on consecutive cycles, the first 1 cycle after the first acceptance.
REQ-038 Assert rst_n=0 for 1 cycle while 2 responses are pending -> rsp_valid=0 immediately, no stale response afterwards, and a full DEPTH-cycle clear reruns.
REQ-039 With DCCM_PARITY_EN, write addr 3 with inj_par_err=1, then read addr 3 -> rsp_err=1; rewrite addr 3 with inj_par_err=0 and read -> rsp_err=0.
